fft_frame_buffer: RTL and testbench

//   Upstream feeder for the FFT stage. Collects audio samples into N-point frames in a

---
 rtl/fft_frame_buffer.sv | 158 +++++++++++++++
 tb/tb_fft_frame_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer feeding an FFT: captures samples into N-point banks
// and streams each completed bank out in bit-reversed order as one burst.
module fft_frame_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] dataOut,
  output logic              FFT_en,
  output logic              frame_start,
  output logic              overflow
);

  localparam int unsigned N      = 1 << N_LOG2;
  localparam int unsigned ADDR_W = N_LOG2 + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [2*N];
  logic [1:0]          full_q, full_d;
  logic                wr_bank_q, rd_bank_q;
  logic [N_LOG2-1:0]   wr_idx_q, rd_idx_q;

  logic                start_c, issue_c, last_c;
  logic                bank_free_c, accept_c, drop_c, wr_last_c;
  logic [ADDR_W-1:0]   wr_addr_c, rd_addr_c;

  // Reverse the N_LOG2 index bits to form the FFT input ordering
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_LOG2); i++) begin
      r[i] = a[int'(N_LOG2) - 1 - i];
    end
    return r;
  endfunction

  // Read FSM next state and per-cycle read strobes
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    issue_c = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q] && frame_ready) begin
          state_d = STREAM;
          start_c = 1'b1;
        end
      end
      STREAM: begin
        issue_c = 1'b1;
        if (rd_idx_q == N_LOG2'(N - 1)) begin
          last_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-side acceptance; a bank freed this cycle is immediately writable
  always_comb begin
    bank_free_c = !full_q[wr_bank_q] || (last_c && (rd_bank_q == wr_bank_q));
    accept_c    = sample_valid && bank_free_c;
    drop_c      = sample_valid && !bank_free_c;
    wr_last_c   = accept_c && (wr_idx_q == N_LOG2'(N - 1));
    wr_addr_c   = {wr_bank_q, wr_idx_q};
    rd_addr_c   = {rd_bank_q, bitrev(rd_idx_q)};
  end

  // Bank full flags: read-side free first, then write-side completion
  always_comb begin
    full_d = full_q;
    for (int b = 0; b < 2; b++) begin
      if (last_c && (rd_bank_q == 1'(b))) begin
        full_d[b] = 1'b0;
      end
      if (wr_last_c && (wr_bank_q == 1'(b))) begin
        full_d[b] = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bank bookkeeping, write/read pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      overflow  <= 1'b0;
    end else begin
      full_q <= full_d;
      if (accept_c) begin
        if (wr_last_c) begin
          wr_idx_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_idx_q <= wr_idx_q + N_LOG2'(1);
        end
      end
      if (drop_c) begin
        overflow <= 1'b1;
        wr_idx_q <= '0;
      end
      if (start_c) begin
        rd_idx_q <= '0;
      end else if (issue_c) begin
        rd_idx_q <= rd_idx_q + N_LOG2'(1);
      end
      if (last_c) begin
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  // Sample storage; contents are not reset
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_addr_c] <= sample_in;
    end
  end

  // Registered read port and burst qualifiers; dataOut holds between bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut     <= '0;
      FFT_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      FFT_en      <= issue_c;
      frame_start <= issue_c && (rd_idx_q == '0);
      if (issue_c) begin
        dataOut <= mem[rd_addr_c];
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Randomized bench for fft_frame_buffer against a frame-queue reference model.
module tb_fft_frame_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_LOG2 = 6;
  localparam int          N      = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] dataOut;
  logic              FFT_en;
  logic              frame_start;
  logic              overflow;

  fft_frame_buffer #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .frame_ready  (frame_ready),
    .dataOut      (dataOut),
    .FFT_en       (FFT_en),
    .frame_start  (frame_start),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: complete frames waiting (at most two), the frame being built,
  // and the frame currently being streamed
  logic [DATA_W-1:0] full_q[$];
  logic [DATA_W-1:0] part_q[$];
  logic [DATA_W-1:0] cur [N];
  int                rem = 0;
  logic              e_en, e_fs, e_ovf;
  logic [DATA_W-1:0] e_dout;

  int run_len = 0;
  int bursts  = 0;
  int words   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int brev(input int a);
    int r;
    r = 0;
    for (int i = 0; i < int'(N_LOG2); i++) begin
      r = r * 2 + ((a >> i) & 1);
    end
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      full_q.delete();
      part_q.delete();
      rem    = 0;
      e_en   = 1'b0;
      e_fs   = 1'b0;
      e_dout = '0;
      e_ovf  = 1'b0;
      return;
    end
    e_en = 1'b0;
    e_fs = 1'b0;
    if (rem > 0) begin
      int k;
      k      = N - rem;
      e_en   = 1'b1;
      e_fs   = (k == 0);
      e_dout = cur[brev(k)];
      rem--;
      if (rem == 0) begin
        repeat (N) void'(full_q.pop_front());
      end
    end else if (full_q.size() >= N && frame_ready) begin
      for (int i = 0; i < N; i++) cur[i] = full_q[i];
      rem = N;
    end
    if (sample_valid) begin
      if (full_q.size() < 2 * N) begin
        part_q.push_back(sample_in);
        if (part_q.size() == N) begin
          foreach (part_q[i]) full_q.push_back(part_q[i]);
          part_q.delete();
        end
      end else begin
        e_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("fft_en", 32'(FFT_en), 32'(e_en));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("data_out", 32'(dataOut), 32'(e_dout));
    if (rst) begin
      run_len = 0;
    end else if (FFT_en) begin
      run_len++;
      words++;
      if (frame_start) bursts++;
    end else if (run_len > 0) begin
      check("burst_len", run_len, N);
      run_len = 0;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] v, input int gap);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    frame_ready  = 1'b0;
    repeat (2) tick();
    rst     = 1'b0;
    bursts  = 0;
    words   = 0;
    run_len = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int en_cnt;
    int guard;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    frame_ready  = 1'b0;

    // Reset values
    do_reset();
    check("rst_fft_en", 32'(FFT_en), 0);
    check("rst_data_out", 32'(dataOut), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Single frame of ramp samples, one every 4th cycle
    frame_ready = 1'b1;
    for (int i = 0; i < N; i++) send(DATA_W'(i), (i < N - 1) ? 3 : 0);
    tick();
    check("t1_lat1_en", 32'(FFT_en), 0);
    tick();
    check("t1_first_en", 32'(FFT_en), 1);
    check("t1_first_fs", 32'(frame_start), 1);
    check("t1_first_word", 32'(dataOut), 0);
    tick();
    check("t1_second_word", 32'(dataOut), 32);
    check("t1_second_fs", 32'(frame_start), 0);
    tick();
    check("t1_third_word", 32'(dataOut), 16);
    repeat (70) tick();
    check("t1_bursts", bursts, 1);

    // Overflow: two full banks held, 129th sample dropped
    do_reset();
    for (int i = 0; i < 2 * N + 1; i++) send(DATA_W'($urandom), 1);
    check("t2_overflow", 32'(overflow), 1);
    frame_ready = 1'b1;
    repeat (200) tick();
    check("t2_overflow_sticky", 32'(overflow), 1);
    check("t2_bursts", bursts, 2);

    // Sustained streaming at one sample every 2nd cycle
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 4 * N; i++) send(DATA_W'($urandom), 1);
    repeat (100) tick();
    check("t3_bursts", bursts, 4);
    check("t3_overflow", 32'(overflow), 0);

    // Held frame until frame_ready rises
    do_reset();
    for (int i = 0; i < N; i++) send(DATA_W'($urandom), 0);
    en_cnt = 0;
    repeat (20) begin
      tick();
      en_cnt += int'(FFT_en);
    end
    check("t4_held_en_count", en_cnt, 0);
    frame_ready = 1'b1;
    tick();
    check("t4_lat1_en", 32'(FFT_en), 0);
    tick();
    check("t4_start_en", 32'(FFT_en), 1);
    check("t4_start_fs", 32'(frame_start), 1);
    repeat (70) tick();
    check("t4_bursts", bursts, 1);

    // Reset at word 10 of a burst, then a fresh frame
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < N; i++) send(DATA_W'($urandom), 0);
    guard = 0;
    while (words < 10 && guard < 300) begin
      tick();
      guard++;
    end
    check("t5_reached_word10", 32'(words >= 10), 1);
    rst = 1'b1;
    tick();
    check("t5_rst_fft_en", 32'(FFT_en), 0);
    check("t5_rst_data_out", 32'(dataOut), 0);
    check("t5_rst_fs", 32'(frame_start), 0);
    check("t5_rst_overflow", 32'(overflow), 0);
    rst     = 1'b0;
    bursts  = 0;
    words   = 0;
    for (int i = 0; i < N; i++) send(DATA_W'($urandom), 1);
    repeat (80) tick();
    check("t5_bursts", bursts, 1);
    check("t5_words", words, N);

    // Free/write collision on bank 0
    do_reset();
    for (int i = 0; i < 2 * N; i++) send(DATA_W'($urandom), 0);
    frame_ready = 1'b1;
    guard = 0;
    while (rem != 1 && guard < 300) begin
      tick();
      guard++;
    end
    check("t6_align_in_budget", 32'(guard < 300), 1);
    send(16'hBEEF, 0);
    check("t6_collision_overflow", 32'(overflow), 0);
    for (int i = 0; i < N - 1; i++) send(DATA_W'($urandom), 1);
    repeat (200) tick();
    check("t6_overflow_final", 32'(overflow), 0);
    check("t6_bursts", bursts, 3);

    // Random traffic with random frame_ready
    do_reset();
    frame_ready = 1'b1;
    repeat (1500) begin
      sample_valid = ($urandom % 3 == 0);
      sample_in    = DATA_W'($urandom);
      if ($urandom % 16 == 0) frame_ready = ~frame_ready;
      tick();
    end
    sample_valid = 1'b0;
    frame_ready  = 1'b1;
    repeat (150) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
